vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator that drives the board's 12-bit colour output. It runs on the pixel clock domain, and an optional `pix_en` input allows a faster system clock. It produces `hs`, `vs`, `de` and `prgb`, all registered and mutually aligned. The active pattern is one of four modes, chosen at runtime and changed only on frame boundaries.

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/vga_timing.sv | 58 +++++
 rtl/vga_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: mode encodings, bar colours,
// default 800x600@72 timing and a counter-width helper.
package vga_pkg;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_GRAD  = 2'd3;

    // Bar colours as {R,G,B} on/off flags, later widened to full channels.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 56;
    localparam int DEF_H_SYNC   = 120;
    localparam int DEF_H_BP     = 64;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 37;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 23;

    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] f;
        case (idx)
            3'd0:    f = BAR_WHITE;
            3'd1:    f = BAR_YELLOW;
            3'd2:    f = BAR_CYAN;
            3'd3:    f = BAR_GREEN;
            3'd4:    f = BAR_MAGENTA;
            3'd5:    f = BAR_RED;
            3'd6:    f = BAR_BLUE;
            default: f = BAR_BLACK;
        endcase
        return f;
    endfunction

    // Counters must also be wide enough for the checker and gradient bit selects.
    function automatic int cnt_width(input int total, input int need);
        int w;
        w = $clog2(total);
        return (w > need) ? w : need;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with active/sync decode and frame-boundary detect.
// Counters advance only on edges with pix_en high.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int HW       = 11,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          hs_act,
    output logic          vs_act,
    output logic          frame_bound
);

    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Raster position: hcnt wraps per line, vcnt steps on each hcnt wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // Region decode from the current raster position.
    always_comb begin
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_act      = (hcnt >= H_SS) && (hcnt < H_SE);
        vs_act      = (vcnt >= V_SS) && (vcnt < V_SE);
        frame_bound = (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus test-pattern mux with a registered, aligned output stage.
// Optional red frame border around the active area when VGA_PAT_BORDER_EN is defined.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   RGB_W    = 4,
    parameter int   CHK_LOG2 = 5,
    parameter int   GRAD_SH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [1:0]         mode,
    input  logic [3*RGB_W-1:0] solid_rgb,
    output logic [3*RGB_W-1:0] prgb,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic               frame_start
);

    localparam int NEED = (GRAD_SH + RGB_W > CHK_LOG2 + 1) ? GRAD_SH + RGB_W : CHK_LOG2 + 1;
    localparam int HW   = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP, NEED);
    localparam int VW   = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP, NEED);

    logic [HW-1:0]        hcnt_s;
    logic [VW-1:0]        vcnt_s;
    logic                 active_s;
    logic                 hs_act_s;
    logic                 vs_act_s;
    logic                 frame_bound_s;
    logic                 border_s;
    logic [1:0]           eff_mode_s;
    logic [3*RGB_W-1:0]   eff_rgb_s;
    logic [2:0]           bar_idx_s;
    logic [2:0]           bar_f_s;
    logic [RGB_W-1:0]     grad_r_s;
    logic [RGB_W-1:0]     grad_g_s;
    logic [3*RGB_W-1:0]   pat_s;
    logic [3*RGB_W-1:0]   pix_s;
    logic [1:0]           mode_q_r;
    logic [3*RGB_W-1:0]   rgb_q_r;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcnt(hcnt_s), .vcnt(vcnt_s),
        .active(active_s), .hs_act(hs_act_s), .vs_act(vs_act_s),
        .frame_bound(frame_bound_s)
    );

`ifdef VGA_PAT_BORDER_EN
    assign border_s = (hcnt_s == '0) || (hcnt_s == HW'(H_ACTIVE - 1)) ||
                      (vcnt_s == '0) || (vcnt_s == VW'(V_ACTIVE - 1));
`else
    logic unused_vcnt_s;
    assign unused_vcnt_s = ^vcnt_s;
    assign border_s      = 1'b0;
`endif

    // Pixel (0,0) already uses the freshly sampled mode so the whole frame shares it.
    always_comb begin
        if (frame_bound_s) begin
            eff_mode_s = mode;
            eff_rgb_s  = solid_rgb;
        end else begin
            eff_mode_s = mode_q_r;
            eff_rgb_s  = rgb_q_r;
        end
    end

    // Bar index = number of constant k*H_ACTIVE/8 boundaries already passed.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcnt_s >= HW'((k * H_ACTIVE) / 8)) begin
                bar_idx_s = bar_idx_s + 3'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    assign bar_f_s  = bar_flags(bar_idx_s);
    assign grad_r_s = hcnt_s[GRAD_SH+RGB_W-1:GRAD_SH];
    assign grad_g_s = vcnt_s[GRAD_SH+RGB_W-1:GRAD_SH];

    // Pattern select, then border override and blanking outside the active area.
    always_comb begin
        pat_s = '0;
        case (eff_mode_s)
            MODE_SOLID: pat_s = eff_rgb_s;
            MODE_BARS:  pat_s = {{RGB_W{bar_f_s[2]}}, {RGB_W{bar_f_s[1]}}, {RGB_W{bar_f_s[0]}}};
            MODE_CHECK: pat_s = (hcnt_s[CHK_LOG2] ^ vcnt_s[CHK_LOG2]) ? '1 : '0;
            MODE_GRAD:  pat_s = {grad_r_s, grad_g_s, grad_r_s ^ grad_g_s};
            default:    pat_s = '0;
        endcase
        if (!active_s) begin
            pix_s = '0;
        end else if (border_s) begin
            pix_s = {{RGB_W{1'b1}}, {(2*RGB_W){1'b0}}};
        end else begin
            pix_s = pat_s;
        end
    end

    // Output stage and frame-boundary mode latch; everything holds while pix_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prgb        <= '0;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_start <= 1'b0;
            mode_q_r    <= MODE_SOLID;
            rgb_q_r     <= '0;
        end else if (pix_en) begin
            prgb        <= pix_s;
            de          <= active_s;
            hs          <= hs_act_s ? HS_POL : ~HS_POL;
            vs          <= vs_act_s ? VS_POL : ~VS_POL;
            frame_start <= frame_bound_s;
            if (frame_bound_s) begin
                mode_q_r <= mode;
                rgb_q_r  <= solid_rgb;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen on a reduced 24x12 raster
// (16x8 active) so whole frames fit in a short run.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic [11:0] prgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        frame_start;

    int passed = 0;
    int total  = 0;
    int nh = 0, nv = 0;    // counter position inside the DUT (next pixel shown)
    int sh = -1, sv = -1;  // pixel currently on the outputs
    int etick = 0;         // enabled edges since start

`ifdef VGA_PAT_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0),
        .RGB_W(4), .CHK_LOG2(2), .GRAD_SH(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
        .prgb(prgb), .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
    );

    function automatic logic [11:0] edge_px(input logic [11:0] plain);
        return BORDER ? 12'hf00 : plain;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        logic en;
        en = pix_en;
        @(posedge clk);
        #1;
        if (en) begin
            etick++;
            sh = nh;
            sv = nv;
            if (nh == 23) begin
                nh = 0;
                nv = (nv == 11) ? 0 : nv + 1;
            end else begin
                nh++;
            end
        end
    endtask

    task automatic goto(input int h, input int v);
        int guard;
        guard = 0;
        while (!(sh == h && sv == v) && guard < 600) begin
            tick();
            guard++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_prgb"}, 32'(prgb), 32'h000);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd0);
        chk({tag, "_vs"}, 32'(vs), 32'd1);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first, e0, guard;
        int          bar_h[11];
        logic [11:0] bar_e[11];
        logic [11:0] idle_e[4];
        logic [11:0] run_e[4];

        bar_h = '{0, 1, 2, 4, 7, 8, 11, 12, 14, 15, 16};
        bar_e = '{edge_px(12'hfff), 12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f,
                  12'hf00, 12'h00f, 12'h000, edge_px(12'h000), 12'h000};
        idle_e = '{12'h312, 12'h312, 12'h415, 12'h415};
        run_e  = '{12'h312, 12'h415, 12'h415, 12'h514};

        rst = 1'b1;
        pix_en = 1'b0;
        mode = 2'd0;
        solid_rgb = 12'h0f0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        // First enabled edge after release shows pixel (0,0)
        rst = 1'b0;
        pix_en = 1'b1;
        tick();
        e0 = etick;
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_de", 32'(de), 32'd1);
        chk("first_prgb", 32'(prgb), 32'(edge_px(12'h0f0)));
        chk("first_hs", 32'(hs), 32'd0);
        chk("first_vs", 32'(vs), 32'd1);
        tick();
        chk("fs_one_pixel", 32'(frame_start), 32'd0);

        // One full line: de 16 pixels, hs 3 pixels from h=18
        goto(23, 0);
        de_cnt = 0;
        hs_cnt = 0;
        hs_first = -1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (de === 1'b1) de_cnt++;
            if (hs === 1'b1) begin
                if (hs_first < 0) hs_first = sh;
                hs_cnt++;
            end
        end
        chk("line_de_count", 32'(de_cnt), 32'd16);
        chk("line_hs_count", 32'(hs_cnt), 32'd3);
        chk("line_hs_start", 32'(hs_first), 32'd18);

        // Mid-frame mode change must not affect the current frame
        goto(8, 4);
        mode = 2'd2;
        solid_rgb = 12'h00f;
        goto(10, 5);
        chk("midframe_hold_a", 32'(prgb), 32'h0f0);
        goto(3, 6);
        chk("midframe_hold_b", 32'(prgb), 32'h0f0);

        // Vertical blanking and sync (VS_POL=0: active low on lines 9..10)
        goto(0, 8);
        chk("vblank_vs", 32'(vs), 32'd1);
        chk("vblank_de", 32'(de), 32'd0);
        chk("vblank_prgb", 32'(prgb), 32'h000);
        goto(0, 9);
        chk("vsync_first", 32'(vs), 32'd0);
        goto(5, 10);
        chk("vsync_last", 32'(vs), 32'd0);
        goto(0, 11);
        chk("vsync_after", 32'(vs), 32'd1);

        // Frame period measured on frame_start
        guard = 0;
        while (frame_start !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        chk("frame_start_seen", 32'(frame_start), 32'd1);
        chk("frame_period", 32'(etick - e0), 32'd288);

        // Checkerboard frame (cells of 4 pixels)
        chk("check_00", 32'(prgb), 32'(edge_px(12'h000)));
        mode = 2'd1;
        goto(4, 1);
        chk("check_4_1", 32'(prgb), 32'hfff);
        goto(1, 4);
        chk("check_1_4", 32'(prgb), 32'hfff);
        goto(4, 4);
        chk("check_4_4", 32'(prgb), 32'h000);
        goto(9, 6);
        chk("check_9_6", 32'(prgb), 32'hfff);

        // Colour bars frame, row 2
        goto(0, 0);
        chk("bars_fs", 32'(frame_start), 32'd1);
        mode = 2'd3;
        for (int i = 0; i < 11; i++) begin
            goto(bar_h[i], 2);
            chk($sformatf("bars_h%0d", bar_h[i]), 32'(prgb), 32'(bar_e[i]));
        end
        chk("bars_blank_de", 32'(de), 32'd0);

        // Gradient frame; frame_start holds across an idle cycle
        goto(0, 0);
        chk("grad_fs", 32'(frame_start), 32'd1);
        pix_en = 1'b0;
        tick();
        chk("idle_fs_hold", 32'(frame_start), 32'd1);
        chk("idle_prgb_00", 32'(prgb), 32'(edge_px(12'h000)));
        pix_en = 1'b1;
        tick();
        chk("fs_after_idle", 32'(frame_start), 32'd0);
        goto(6, 3);
        chk("grad_6_3", 32'(prgb), 32'h312);
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'b0;
            tick();
            chk($sformatf("toggle_idle%0d", i), 32'(prgb), 32'(idle_e[i]));
            pix_en = 1'b1;
            tick();
            chk($sformatf("toggle_run%0d", i), 32'(prgb), 32'(run_e[i]));
        end
        goto(0, 5);
        chk("grad_0_5", 32'(prgb), 32'(edge_px(12'h022)));
        goto(13, 6);
        chk("grad_13_6", 32'(prgb), 32'h635);
        goto(8, 7);
        chk("grad_8_7", 32'(prgb), 32'h437);

        // Reset mid-line takes effect immediately, next frame restarts at (0,0)
        rst = 1'b1;
        #1;
        chk_reset_vals("midreset");
        nh = 0;
        nv = 0;
        mode = 2'd0;
        solid_rgb = 12'habc;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rerun_fs", 32'(frame_start), 32'd1);
        chk("rerun_prgb", 32'(prgb), 32'(edge_px(12'habc)));
        goto(5, 2);
        chk("rerun_solid", 32'(prgb), 32'habc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
